// File: rtl/resp_misr_capture.sv
// Response MISR compactor: captures valid CUT response words into a signature under a start/capture/done FSM.
// Optional SIG_COMPARE_EN adds expected_sig input and pass/fail outputs, evaluated on entry to DONE.
module resp_misr_capture #(
    parameter int                 WIDTH   = 13,
    parameter int                 SIG_W   = 16,
    parameter logic [SIG_W-1:0]   POLY    = 16'h1021,
    parameter logic [SIG_W-1:0]   SEED    = 16'h0000,
    parameter int                 COUNT_W = 16
) (
    input  logic               blif_clk_net,
    input  logic               blif_reset_net,
    input  logic               start,
    input  logic               abort,
    input  logic [COUNT_W-1:0] num_patterns,
    input  logic               resp_valid,
    input  logic [WIDTH-1:0]   resp_data,
`ifdef SIG_COMPARE_EN
    input  logic [SIG_W-1:0]   expected_sig,
    output logic               pass,
    output logic               fail,
`endif
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] pat_count,
    output logic [SIG_W-1:0]   signature
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [COUNT_W-1:0] tgt_q, tgt_d;
    logic               start_acc;

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                   input logic [WIDTH-1:0] d);
        misr_step = (s << 1) ^ (s[SIG_W-1] ? POLY : '0) ^ SIG_W'(d);
    endfunction

    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
        end
    end

    // abort outranks both start and capture in every state
    always_comb begin
        state_d   = state_q;
        sig_d     = sig_q;
        cnt_d     = cnt_q;
        tgt_d     = tgt_q;
        start_acc = 1'b0;
        case (state_q)
            CAPTURE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (resp_valid) begin
                    sig_d = misr_step(sig_q, resp_data);
                    cnt_d = cnt_q + COUNT_W'(1);
                    if (cnt_q == tgt_q - COUNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (start) begin
                    start_acc = 1'b1;
                    sig_d     = SEED;
                    cnt_d     = '0;
                    tgt_d     = num_patterns;
                    state_d   = (num_patterns == '0) ? DONE : CAPTURE;
                end
            end
        endcase
    end

    assign busy      = (state_q == CAPTURE);
    assign done      = (state_q == DONE);
    assign pat_count = cnt_q;
    assign signature = sig_q;

`ifdef SIG_COMPARE_EN
    logic pass_q, pass_d;
    logic fail_q, fail_d;
    logic enter_done;

    // a zero-length start lands in DONE directly and still counts as an entry
    assign enter_done = (state_d == DONE) && ((state_q != DONE) || start_acc);

    always_comb begin
        pass_d = pass_q;
        fail_d = fail_q;
        if (abort) begin
            pass_d = 1'b0;
            fail_d = 1'b0;
        end else if (enter_done) begin
            pass_d = (sig_d == expected_sig);
            fail_d = (sig_d != expected_sig);
        end else if (start_acc) begin
            pass_d = 1'b0;
            fail_d = 1'b0;
        end
    end

    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            pass_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            pass_q <= pass_d;
            fail_q <= fail_d;
        end
    end

    assign pass = pass_q;
    assign fail = fail_q;
`endif

endmodule

// File: doc/resp_misr_capture.md
Name: resp_misr_capture

Overview:
- Downstream response compactor for the merged sequential/combinational pattern netlists.
- Captures each valid response word from the circuit under test (CUT) outputs into a multiple-input signature register (MISR).
- Counts captured patterns and runs a start/capture/done state machine.
- The final signature goes to the graph-grammar evaluation flow, so one signature is compared instead of every output vector.

Parameters:
- WIDTH, 13, CUT response width in bits; must be <= SIG_W.
- SIG_W, 16, signature register width.
- POLY, 16'h1021, MISR feedback polynomial; bit i set means XOR into bit i on MSB feedback.
- SEED, 16'h0000, value loaded into the signature on start.
- COUNT_W, 16, width of the pattern counter and num_patterns.

Ports:
- blif_clk_net  input  1  sole clock; all state updates on rising edge.
- blif_reset_net  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a capture run; honoured only in IDLE or DONE.
- abort  input  1  forces return to IDLE; signature and count are held.
- num_patterns  input  COUNT_W  number of responses to capture; sampled on the accepted start.
- resp_valid  input  1  resp_data is a valid CUT response this cycle.
- resp_data  input  WIDTH  CUT response vector, e.g. the 13 primary outputs of a merged pattern netlist.
- busy  output  1  high in CAPTURE.
- done  output  1  high in DONE; sticky until start or abort.
- pat_count  output  COUNT_W  responses captured in the current run.
- signature  output  SIG_W  current MISR contents.

Behaviour:
- Reset (async, active-high):
  - state = IDLE; signature = SEED; pat_count = 0; stored target = 0.
  - busy = 0; done = 0.
- States and transitions:
  - IDLE: start with num_patterns != 0 → CAPTURE. start with num_patterns == 0 → DONE.
  - CAPTURE: a capture with pat_count == target-1 → DONE. abort → IDLE.
  - DONE: start restarts exactly as from IDLE. abort → IDLE.
- Start acceptance (IDLE or DONE):
  - signature <= SEED; pat_count <= 0; target <= num_patterns. All take effect in the same edge as the state change.
  - start while in CAPTURE is ignored; no reload, no count change.
- Capture, in CAPTURE with resp_valid = 1:
  - signature <= (signature << 1) ^ (signature[SIG_W-1] ? POLY : 0) ^ zero_extend(resp_data).
  - pat_count <= pat_count + 1.
  - resp_valid = 0 holds signature and count unchanged.
- resp_valid outside CAPTURE is ignored.
- Latency:
  - The signature including the last response is visible on the cycle after the final capture edge.
  - done rises on that same cycle; busy falls on it.
- Simultaneous events:
  - abort has priority over start and over capture in the same cycle.
  - A final capture with abort in the same cycle: nothing is captured; state goes to IDLE.
- pat_count never wraps in normal operation, because target <= 2^COUNT_W-1 ends the run first.
- Reset asserted mid-run aborts immediately to reset values; no partial done.

Optional Feature:
- Macro SIG_COMPARE_EN.
- When defined, adds:
  - input expected_sig [SIG_W]
  - output pass [1]
  - output fail [1]
- pass/fail behaviour with the macro:
  - Both reset to 0 and clear on accepted start.
  - On entry to DONE, pass <= (final signature == expected_sig) and fail <= !pass. expected_sig is sampled on that entry edge.
  - Both hold until the next start, abort or reset.
- When undefined: the ports are absent and no comparator is built.

Test Plan:
- Reset mid-CAPTURE → signature = 16'h0000, pat_count = 0, busy = 0, done = 0; then stable with start = 0.
- SEED = 0, start with num_patterns = 3; responses 13'h0001, 13'h0002, 13'h1FFF with resp_valid gaps between them:
  - signature sequence 16'h0001, 16'h0000, 16'h1FFF.
  - done = 1 one cycle after the third capture; pat_count = 3.
- SEED = 16'hFFFF, num_patterns = 1, resp_data = 0 → signature = 16'hEFDF (MSB feedback path); done = 1.
- start with num_patterns = 0 → DONE next cycle; signature = SEED; resp_valid pulses ignored.
- In CAPTURE: start pulse → ignored (count continues). abort asserted together with resp_valid → IDLE; signature and count unchanged.
- With SIG_COMPARE_EN:
  - expected_sig = 16'h1FFF on the 3-response run → pass = 1, fail = 0.
  - expected_sig = 16'h1FFE → pass = 0, fail = 1.
  - A new start clears both.
